// File: rtl/biriscv_div_issue_ctrl_pkg.sv
// Shared definitions for the divider issue controller: FSM states and
// RV32M divide-class opcode decode constants.
package biriscv_div_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } div_state_e;

  localparam logic [31:0] INST_DIV       = 32'h02004033;
  localparam logic [31:0] INST_DIVU      = 32'h02005033;
  localparam logic [31:0] INST_REM       = 32'h02006033;
  localparam logic [31:0] INST_REMU      = 32'h02007033;
  localparam logic [31:0] INST_DIV_MASK  = 32'hfe00707f;
  // funct3[2] set with the MULDIV funct7 selects the whole divide class
  localparam logic [31:0] INST_DIVC_MASK = 32'hfe00407f;

  function automatic logic is_div_class(input logic [31:0] opcode);
    return (opcode & INST_DIVC_MASK) == INST_DIV;
  endfunction

endpackage

// File: rtl/biriscv_div_issue_ctrl.sv
// Divider initiator: accepts one divide-class op at a time, launches it,
// forwards the result to the register file and guards against a hung divider.
module biriscv_div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [31:0] issue_opcode_i,
  input  logic [31:0] issue_pc_i,
  input  logic [4:0]  issue_rd_idx_i,
  input  logic [31:0] issue_ra_operand_i,
  input  logic [31:0] issue_rb_operand_i,
  input  logic        flush_i,
  input  logic [4:0]  hazard_ra_idx_i,
  input  logic [4:0]  hazard_rb_idx_i,
  output logic        hazard_o,
  output logic        div_opcode_valid_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_pc_o,
  output logic [4:0]  div_rd_idx_o,
  output logic [31:0] div_ra_operand_o,
  output logic [31:0] div_rb_operand_o,
  input  logic        div_wb_valid_i,
  input  logic [31:0] div_wb_value_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [31:0] wb_value_o,
  output logic        busy_o,
  output logic        timeout_o
);
  import biriscv_div_issue_ctrl_pkg::*;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [31:0]      r_opcode;
  logic [31:0]      r_pc;
  logic [4:0]       r_rd;
  logic [31:0]      r_ra;
  logic [31:0]      r_rb;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_value;
  logic             r_timeout;
  logic             w_idle;
  logic             w_accept;
  logic             w_wb_take;
  logic             w_timeout_hit;

  assign w_idle   = (r_state == ST_IDLE);
  // Ready is held low while reset is asserted so nothing is accepted mid-reset
  assign w_accept = issue_valid_i & issue_ready_o & ~flush_i;

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_wb_take     = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_cnt_next   = '0;
        w_state_next = flush_i ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (div_wb_valid_i) begin
          w_wb_take    = ~flush_i;
          w_state_next = ST_IDLE;
        end else if (flush_i) begin
          w_state_next = ST_DRAIN;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_timeout_hit = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (div_wb_valid_i) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_timeout_hit = 1'b1;
          w_state_next  = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opcode <= '0;
      r_pc     <= '0;
      r_rd     <= '0;
      r_ra     <= '0;
      r_rb     <= '0;
    end else if (w_accept) begin
      r_opcode <= issue_opcode_i;
      r_pc     <= issue_pc_i;
      r_rd     <= issue_rd_idx_i;
      r_ra     <= issue_ra_operand_i;
      r_rb     <= issue_rb_operand_i;
    end
  end

  // x0 writes are dropped at the enable but index/data still track the result
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_value <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wb_valid <= w_wb_take & (r_rd != 5'd0);
      if (w_wb_take) begin
        r_wb_rd    <= r_rd;
        r_wb_value <= div_wb_value_i;
      end
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  assign issue_ready_o      = rst_ni & w_idle;
  assign busy_o             = ~w_idle;
  assign div_opcode_valid_o = (r_state == ST_LAUNCH);
  assign div_opcode_o       = r_opcode;
  assign div_pc_o           = r_pc;
  assign div_rd_idx_o       = r_rd;
  assign div_ra_operand_o   = r_ra;
  assign div_rb_operand_o   = r_rb;
  assign wb_valid_o         = r_wb_valid;
  assign wb_rd_idx_o        = r_wb_rd;
  assign wb_value_o         = r_wb_value;
  assign timeout_o          = r_timeout;
  assign hazard_o = ((r_state == ST_LAUNCH) || (r_state == ST_WAIT)) && (r_rd != 5'd0) &&
                    ((hazard_ra_idx_i == r_rd) || (hazard_rb_idx_i == r_rd));

endmodule
